imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 81 ++++++++
 tb/tb_imm_ext_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender: sign/zero/upper/branch-offset extension in a two-stage valid/ready pipe.
// Latency: 2 cycles from accepted input to out_valid; one result per cycle with out_ready high.
// Backpressure: S2 holds while out_ready is low, S1 fills behind it, then in_ready drops.
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   localparam int EXT_W = OUT_W - IN_W;

   logic             s1_vld;
   logic [IN_W-1:0]  s1_imm;
   logic [1:0]       s1_mode;
   logic             s2_vld;
   logic [OUT_W-1:0] s2_dat;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext_dat;
   logic             s1_load;
   logic             s2_load;

   assign s2_load   = s1_vld && (!s2_vld || out_ready);
   assign in_ready  = !flush && (!s1_vld || s2_load);
   assign s1_load   = in_valid && in_ready;
   assign out_valid = s2_vld;
   assign out_data  = s2_dat;

   always_comb begin
      sext = {{EXT_W{s1_imm[IN_W-1]}}, s1_imm};
      case (s1_mode)
         2'b00:   ext_dat = sext;
         2'b01:   ext_dat = {{EXT_W{1'b0}}, s1_imm};
         2'b10:   ext_dat = {s1_imm, {EXT_W{1'b0}}};
         default: ext_dat = {sext[OUT_W-3:0], 2'b00};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_vld  <= 1'b0;
         s1_imm  <= '0;
         s1_mode <= '0;
         s2_vld  <= 1'b0;
         s2_dat  <= '0;
      end else begin
         if (flush)
            s1_vld <= 1'b0;
         else if (s1_load)
            s1_vld <= 1'b1;
         else if (s2_load)
            s1_vld <= 1'b0;

         if (s1_load) begin
            s1_imm  <= in_imm;
            s1_mode <= in_mode;
         end

         // A flush still lets a result already offered with out_ready count as consumed.
         if (flush)
            s2_vld <= 1'b0;
         else if (s2_load)
            s2_vld <= 1'b1;
         else if (out_ready)
            s2_vld <= 1'b0;

         if (s2_load && !flush)
            s2_dat <= ext_dat;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: vector table, backpressure/flush/reset sequences, random burst,
// all outputs checked against a scoreboard queue filled when inputs are accepted.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;

   imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] dat; int acc; } exp_t;
   typedef struct { logic [15:0] imm; logic [1:0] mode; logic [31:0] exp; } vec_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          n_out = 0;
   bit          lat_chk = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_dat = '0;
   logic [31:0] drv_exp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
      int s;
      s = int'($signed(imm));
      case (mode)
         2'd0:    return s;
         2'd1:    return {16'h0000, imm};
         2'd2:    return {imm, 16'h0000};
         default: return s * 4;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [31:0] exp);
      in_valid = v;
      in_imm   = imm;
      in_mode  = mode;
      drv_exp  = exp;
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard and hold-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_dat);
         end
         if (q.size() == 0)
            chk("spurious_out", out_valid, 0);
         else if (out_valid && out_ready) begin
            mon_e = q.pop_front();
            chk("out_data", out_data, mon_e.dat);
            if (lat_chk) chk("latency", cyc - mon_e.acc, 2);
            n_out++;
         end
         prev_hold = out_valid && !out_ready && !flush;
         prev_dat  = out_data;
         if (flush) q.delete();
         if (in_valid && in_ready) q.push_back('{drv_exp, cyc});
      end
   end

   vec_t        vecs[8];
   logic [15:0] bp_imm[4];
   logic [1:0]  bp_mode[4];
   logic [31:0] bp_exp[4];
   int          idx;
   int          n0;
   logic [15:0] r_imm;
   logic [1:0]  r_mode;

   initial begin
      vecs[0] = '{16'h8000, 2'd0, 32'hFFFF8000};
      vecs[1] = '{16'h8000, 2'd1, 32'h00008000};
      vecs[2] = '{16'h1234, 2'd2, 32'h12340000};
      vecs[3] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
      vecs[4] = '{16'h4001, 2'd3, 32'h00010004};
      vecs[5] = '{16'h7FFF, 2'd0, 32'h00007FFF};
      vecs[6] = '{16'hFFFF, 2'd2, 32'hFFFF0000};
      vecs[7] = '{16'h8000, 2'd3, 32'hFFFE0000};
      bp_imm  = '{16'h0001, 16'h8001, 16'hABCD, 16'h0003};
      bp_mode = '{2'd0, 2'd1, 2'd2, 2'd3};
      bp_exp  = '{32'h00000001, 32'h00008001, 32'hABCD0000, 32'h0000000C};

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Vector table at full throughput
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         drive(1, vecs[i].imm, vecs[i].mode, vecs[i].exp);
         chk("tp_in_ready", in_ready, 1);
         tick();
      end
      drive(0, 16'h0, 2'd0, 32'h0);
      tick();
      tick();
      tick();
      chk("tp_count", n_out - n0, 8);

      // Backpressure: four back-to-back inputs with out_ready low for five cycles
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         drive(1, bp_imm[idx], bp_mode[idx], bp_exp[idx]);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         tick();
      end
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, bp_exp[0]);
      out_ready = 1'b1;
      n0 = n_out;
      for (int c = 0; c < 10 && idx < 4; c++) begin
         drive(1, bp_imm[idx], bp_mode[idx], bp_exp[idx]);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         tick();
      end
      drive(0, 16'h0, 2'd0, 32'h0);
      chk("bp_all_accepted", idx, 4);
      tick();
      tick();
      chk("bp_drain_count", n_out - n0, 4);

      // Flush with both stages full and out_ready low
      out_ready = 1'b0;
      drive(1, 16'h1111, 2'd0, 32'h00001111);
      tick();
      drive(1, 16'h2222, 2'd1, 32'h00002222);
      tick();
      drive(1, 16'h3333, 2'd0, 32'h00003333);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      drive(1, 16'h7FFF, 2'd0, 32'h00007FFF);
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      tick();
      drive(0, 16'h0, 2'd0, 32'h0);
      chk("post_flush_lat1", out_valid, 0);
      tick();
      chk("post_flush_valid", out_valid, 1);
      chk("post_flush_data", out_data, 32'h00007FFF);
      tick();

      // Flush coinciding with a consumed result
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      n0 = n_out;
      drive(1, 16'h00F0, 2'd1, 32'h000000F0);
      tick();
      drive(0, 16'h0, 2'd0, 32'h0);
      tick();
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_consume_count", n_out - n0, 1);
      chk("flush_consume_valid", out_valid, 0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      drive(1, 16'h1234, 2'd2, 32'h12340000);
      tick();
      drive(1, 16'hFFFF, 2'd3, 32'hFFFFFFFC);
      tick();
      drive(0, 16'h0, 2'd0, 32'h0);
      chk("pre_arst_valid", out_valid, 1);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("no_stale_valid", out_valid, 0);
      n0 = n_out;
      lat_chk = 1'b1;
      drive(1, 16'h4001, 2'd3, 32'h00010004);
      tick();
      drive(0, 16'h0, 2'd0, 32'h0);
      tick();
      tick();
      chk("post_arst_count", n_out - n0, 1);

      // Random traffic with random backpressure
      lat_chk = 1'b0;
      for (int c = 0; c < 80; c++) begin
         r_imm     = 16'($urandom);
         r_mode    = 2'($urandom_range(0, 3));
         out_ready = 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)), r_imm, r_mode, model(r_imm, r_mode));
         tick();
      end
      drive(0, 16'h0, 2'd0, 32'h0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("drain_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
